ppfifo_stream_writer: RTL

- Upstream feeder for the load-input ping-pong buffer.
- Converts a valid/ready/last word stream into that buffer's write-side protocol. Protocol signals: per-half ready, one-hot activate, write strobe, data.
- Picks a free half and fills it until the half is full, the packet ends, or the input idles. Then releases the half so the read side can drain it while the other half fills.

---
 rtl/ppfifo_pkg.sv | 16 +
 rtl/ppfifo_half_select.sv | 29 ++
 rtl/ppfifo_stream_writer.sv | 126 ++++++++++++
 3 files changed

// File: rtl/ppfifo_pkg.sv
// Shared definitions for the ping-pong buffer writer and reader side.
//   wr_state_e : writer FSM encoding (idle, fill a half, release a half)
//   HALF0/HALF1/NONE : one-hot half-activate codes used on the buffer interface
package ppfifo_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StFill    = 2'd1,
    StRelease = 2'd2
  } wr_state_e;

  localparam logic [1:0] HALF0 = 2'b01;
  localparam logic [1:0] HALF1 = 2'b10;
  localparam logic [1:0] NONE  = 2'b00;

endpackage

// File: rtl/ppfifo_half_select.sv
// Combinational choice of a ping-pong half from the per-half ready flags.
//   i_ready  : per-half "available" flags from the buffer
//   i_next   : round-robin pointer, used only when both halves are available
//   o_sel    : one-hot selected half (NONE when neither is available)
//   o_toggle : caller should flip its round-robin pointer if it takes o_sel
module ppfifo_half_select
  import ppfifo_pkg::*;
(
  input  logic [1:0] i_ready,
  input  logic       i_next,
  output logic [1:0] o_sel,
  output logic       o_toggle
);

  always_comb begin
    o_sel    = NONE;
    o_toggle = 1'b0;
    case (i_ready)
      2'b01:   o_sel = HALF0;
      2'b10:   o_sel = HALF1;
      2'b11: begin
        o_sel    = i_next ? HALF1 : HALF0;
        o_toggle = 1'b1;
      end
      default: o_sel = NONE;
    endcase
  end

endmodule

// File: rtl/ppfifo_stream_writer.sv
// Feeds a valid/ready/last word stream into one half of a ping-pong buffer at a time.
// A free half is picked in IDLE, filled in FILL until it is full, the packet ends or the
// input idles too long with a partial half, then handed back for one RELEASE cycle.
//   i_clk, i_rst_n      : clock, asynchronous active-low reset
//   i_s_valid/o_s_ready : upstream handshake; i_s_data word, i_s_last end of packet
//   i_wr_ready          : per-half "empty and writable" from the buffer (sampled in IDLE)
//   i_wr_fifo_size      : words per half
//   o_wr_activate       : one-hot half being written, 00 when none
//   o_wstrobe/o_wdata   : write one word into the active half (pass-through of the stream)
//   o_busy              : writer is filling or releasing a half
//   o_fill_cnt          : words written into the current half
//   o_buf_cnt           : halves released since reset (wraps)
module ppfifo_stream_writer
  import ppfifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 16,
  parameter int unsigned SIZE_WIDTH   = 16,
  parameter int unsigned IDLE_TIMEOUT = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_s_valid,
  output logic                  o_s_ready,
  input  logic [DATA_WIDTH-1:0] i_s_data,
  input  logic                  i_s_last,
  input  logic [1:0]            i_wr_ready,
  input  logic [SIZE_WIDTH-1:0] i_wr_fifo_size,
  output logic [1:0]            o_wr_activate,
  output logic                  o_wstrobe,
  output logic [DATA_WIDTH-1:0] o_wdata,
  output logic                  o_busy,
  output logic [SIZE_WIDTH-1:0] o_fill_cnt,
  output logic [15:0]           o_buf_cnt
);

  // Wide enough to hold IDLE_TIMEOUT with headroom so saturation never hides the hit.
  localparam int unsigned TimerWidth = $clog2(IDLE_TIMEOUT + 2);
  localparam logic [TimerWidth-1:0] TimeoutVal = TimerWidth'(IDLE_TIMEOUT);
  localparam logic [TimerWidth-1:0] TimerMax   = '1;

  wr_state_e             state_q;
  logic                  next_half_q;
  logic [SIZE_WIDTH-1:0] limit_q;
  logic [SIZE_WIDTH-1:0] fill_cnt_q;
  logic [TimerWidth-1:0] idle_q;
  logic [1:0]            activate_q;
  logic [15:0]           buf_cnt_q;

  logic [1:0] sel;
  logic       sel_toggle;
  logic       strobe;
  logic       full_hit;
  logic       last_hit;
  logic       timeout_hit;
  logic       close;

  ppfifo_half_select u_half_select (
    .i_ready  (i_wr_ready),
    .i_next   (next_half_q),
    .o_sel    (sel),
    .o_toggle (sel_toggle)
  );

  assign o_s_ready = (state_q == StFill);
  assign strobe    = i_s_valid & o_s_ready;

  assign full_hit    = strobe && ((fill_cnt_q + SIZE_WIDTH'(1)) == limit_q);
  assign last_hit    = strobe && i_s_last;
  // A half with no words is never released, however long the input idles.
  assign timeout_hit = (IDLE_TIMEOUT != 0) && (state_q == StFill) &&
                       (idle_q == TimeoutVal) && (fill_cnt_q != '0);
  assign close       = full_hit | last_hit | timeout_hit;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= StIdle;
      next_half_q <= 1'b0;
      limit_q     <= '0;
      fill_cnt_q  <= '0;
      idle_q      <= '0;
      activate_q  <= NONE;
      buf_cnt_q   <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if ((i_wr_ready != NONE) && (i_wr_fifo_size != '0)) begin
            activate_q <= sel;
            limit_q    <= i_wr_fifo_size;
            fill_cnt_q <= '0;
            idle_q     <= '0;
            if (sel_toggle) next_half_q <= ~next_half_q;
            state_q    <= StFill;
          end
        end
        StFill: begin
          if (strobe) begin
            fill_cnt_q <= fill_cnt_q + SIZE_WIDTH'(1);
            idle_q     <= '0;
          end else if ((fill_cnt_q != '0) && (idle_q != TimerMax)) begin
            idle_q <= idle_q + TimerWidth'(1);
          end
          if (close) begin
            activate_q <= NONE;
            state_q    <= StRelease;
          end
        end
        StRelease: begin
          buf_cnt_q <= buf_cnt_q + 16'd1;
          state_q   <= StIdle;
        end
        default: begin
          activate_q <= NONE;
          state_q    <= StIdle;
        end
      endcase
    end
  end

  assign o_wstrobe     = strobe;
  assign o_wdata       = i_s_data;
  assign o_wr_activate = activate_q;
  assign o_busy        = (state_q != StIdle);
  assign o_fill_cnt    = fill_cnt_q;
  assign o_buf_cnt     = buf_cnt_q;

endmodule
